// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with KMP fallback, overlap and Mealy/Moore options.
// Optional saturating match counter built only when SEQ_DET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int              LEN     = 4,
  parameter logic [LEN-1:0]  PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter bit              MEALY   = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             SW    = $clog2(LEN);
  localparam int             DEPTH = 1 << SW;
  localparam logic [SW-1:0]  LAST  = SW'(LEN - 1);

  function automatic logic pbit(input int i);
    logic [LEN-1:0] t;
    t = PATTERN >> (LEN - 1 - i);
    return t[0];
  endfunction

  // Longest proper prefix that is a suffix of (first k bits, b).
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    best = 0;
    for (int j = 1; j < LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          idx = k + 1 - j + i;
          if (idx == k) ok = ok & (pbit(i) == b);
          else          ok = ok & (pbit(i) == pbit(idx));
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] nxt_tab [DEPTH][2];

  for (genvar gk = 0; gk < DEPTH; gk++) begin : g_k
    for (genvar gb = 0; gb < 2; gb++) begin : g_b
      if (gk < LEN) begin : g_v
        assign nxt_tab[gk][gb] = SW'(kmp_next(gk, gb != 0));
      end else begin : g_z
        assign nxt_tab[gk][gb] = '0;
      end
    end
  end

  logic [SW-1:0] k_q, k_d;
  logic          hit_last;

  always_comb begin
    hit_last = en && (k_q == LAST) && (in == PATTERN[0]);
    k_d      = k_q;
    if (en) begin
      if (hit_last && !OVERLAP) k_d = '0;
      else                      k_d = nxt_tab[k_q][in];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) k_q <= '0;
    else     k_q <= k_d;
  end

  if (MEALY) begin : g_mealy
    assign out = hit_last & ~rst;
  end else begin : g_moore
    logic out_q, out_d;
    always_comb out_d = hit_last;
    always_ff @(posedge clk) begin
      if (rst) out_q <= 1'b0;
      else     out_q <= out_d;
    end
    assign out = out_q;
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (hit_last && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
